// File: rtl/irq_ctrl.sv
// Prioritising interrupt controller: edge-latched pending, mask, in-service tracking, one request to CP0.
// Latency: src edge -> PEND at +1 edge -> int_req/int_id at +2 edges; rdata is combinational from addr.
// Backpressure: request held until int_ack or withdrawn; optional nesting via IRQ_CTRL_NEST_EN.
module irq_ctrl #(
    parameter int          N_SRC     = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic             we,
    output logic [31:0]      rdata,
    output logic             int_req,
    output logic [4:0]       int_id,
    input  logic             int_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [4:0]       id_nxt;

    logic [N_SRC-1:0] mask_r;
    logic [N_SRC-1:0] pend_r;
    logic [N_SRC-1:0] isr_r;
    logic [N_SRC-1:0] src_q;

    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] isr_set;
    logic [N_SRC-1:0] isr_clr;
    logic [N_SRC-1:0] eoi_rem;
    logic [4:0]       best;
    logic [4:0]       isr_top;
    logic             cur_elig;

    logic             sel;
    logic             wr_mask;
    logic             wr_pend;
    logic             wr_eoi;
    logic             unused_bits;

    // Lowest set index wins (index 0 is the highest priority).
    function automatic logic [4:0] lowest(input logic [N_SRC-1:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) r = 5'(i);
        end
        return r;
    endfunction

    function automatic logic [N_SRC-1:0] bit_of(input logic [4:0] idx);
        logic [N_SRC-1:0] v;
        v    = '0;
        v[0] = 1'b1;
        return v << idx;
    endfunction

    // 33-bit compare so a window near the top of the address space cannot wrap.
    assign sel     = ({1'b0, addr} >= {1'b0, BASE_ADDR}) &&
                     ({1'b0, addr} <= ({1'b0, BASE_ADDR} + 33'hF));
    assign wr_mask = we && sel && (addr[3:2] == 2'd0);
    assign wr_pend = we && sel && (addr[3:2] == 2'd1);
    assign wr_eoi  = we && sel && (addr[3:2] == 2'd3);

    // Only the low N_SRC data bits carry register content.
    assign unused_bits = &{1'b0, wdata};

    assign rise     = src & ~src_q;
    assign w1c      = wr_pend ? wdata[N_SRC-1:0] : '0;
    assign elig     = pend_r & mask_r & ~isr_r;
    assign best     = lowest(elig);
    assign isr_top  = lowest(isr_r);
    assign cur_elig = |(elig & bit_of(int_id));
    assign eoi_rem  = isr_r & ~bit_of(isr_top);

    // Register read mux; anything outside the window or unused reads as zero.
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr[3:2])
                2'd0:    rdata[N_SRC-1:0] = mask_r;
                2'd1:    rdata[N_SRC-1:0] = pend_r;
                2'd2:    rdata = {int_req, |isr_r, 25'd0, int_id};
                default: rdata = '0;
            endcase
        end
    end

    // Scheduler: pick the best eligible source, hold the request, track in-service nesting.
    always_comb begin
        state_nxt = state;
        id_nxt    = int_id;
        isr_set   = '0;
        isr_clr   = '0;
        case (state)
            IDLE: begin
                if (|elig) begin
                    state_nxt = REQ;
                    id_nxt    = best;
                end
            end
            REQ: begin
                if (int_ack) begin
                    isr_set   = bit_of(int_id);
                    state_nxt = SERVICE;
                end else if (!cur_elig) begin
                    // Source masked or cleared before the CPU took it: withdraw.
                    if (|isr_r) begin
                        state_nxt = SERVICE;
                        id_nxt    = isr_top;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            SERVICE: begin
                if (wr_eoi) begin
                    isr_clr = bit_of(isr_top);
                    if (|eoi_rem) begin
                        state_nxt = SERVICE;
                        id_nxt    = lowest(eoi_rem);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
`ifdef IRQ_CTRL_NEST_EN
                else if ((|elig) && (best < int_id)) begin
                    state_nxt = REQ;
                    id_nxt    = best;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, request and register file update; a new edge beats a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_r  <= '0;
            pend_r  <= '0;
            isr_r   <= '0;
            src_q   <= '0;
            state   <= IDLE;
            int_req <= 1'b0;
            int_id  <= '0;
        end else begin
            src_q <= src;
            if (wr_mask) mask_r <= wdata[N_SRC-1:0];
            pend_r  <= (pend_r & ~w1c & ~isr_set) | rise;
            isr_r   <= (isr_r | isr_set) & ~isr_clr;
            state   <= state_nxt;
            int_id  <= id_nxt;
            int_req <= (state_nxt == REQ);
        end
    end

endmodule
